multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 opcode  in  6  IR[31:26], valid from DECODE onward.
REQ-004 funct  in  6  IR[5:0].
REQ-005 zero  in  1  ALU zero flag, combinational from the current ALU operands.
REQ-006 mem_ready  in  1  memory handshake; the access completes in the cycle it is high.
REQ-007 ALUOp  out  4  class code to ALU control: R=0111, LUI=0110, ORI=0101, ADDI/add=0100, SW=0011, LW=0010, ANDI=0001, BEQ=1000, BNE=1001.
REQ-008 pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a  out  1 each  datapath strobes and selects.
REQ-009 pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
REQ-010 alu_src_b  out  2  ALU operand B: 00 B, 01 constant 4, 10 sext(imm), 11 sext(imm)<<2.
REQ-011 reg_dst  out  2  register destination: 00 rt, 01 rd, 10 $31.
REQ-012 mem_to_reg  out  2  write-back source: 00 ALUOut, 01 MDR, 10 PC.
REQ-013 state_o  out  4  current state encoding.
REQ-014 illegal  out  1  sticky unsupported-opcode flag.
REQ-015 retired  out  16  count of completed instructions.

Function
REQ-016 States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, JR=12, TRAP=15.
REQ-017 Outputs are decoded from state; defaults are all strobes 0, all selects 0, and ALUOp=0100.
REQ-018 FETCH: mem_read=1, i_or_d=0, alu_src_b=01; ir_write and pc_write are asserted only while mem_ready=1; the FSM stays in FETCH while mem_ready=0.
REQ-019 DECODE: alu_src_b=11, ALUOp=0100 (branch target into ALUOut); next state by opcode:
- 000000 with funct 001000 -> JR
- other 000000 -> EXEC_R
- 100011/101011 -> MEM_ADDR
- 001000/001100/001101/001111 -> EXEC_I
- 000100/000101 -> BRANCH
- 000010/000011 -> JUMP
- anything else -> TRAP
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=0010 for LW and 0011 for SW; next state MEM_READ for LW, MEM_WRITE for SW.
REQ-021 MEM_READ and MEM_WRITE: i_or_d=1 and the matching strobe are held until mem_ready=1; that cycle advances to MEM_WB (LW) or FETCH (SW).
REQ-022 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01.
REQ-023 EXEC_R: alu_src_a=1, ALUOp=0111. R_WB: reg_write=1, reg_dst=01.
REQ-024 EXEC_I: alu_src_a=1, alu_src_b=10, ALUOp per opcode (0100/0001/0101/0110). I_WB: reg_write=1, reg_dst=00.
REQ-025 BRANCH: alu_src_a=1, ALUOp=1000 (BEQ) or 1001 (BNE), pc_src=01; pc_write=zero for BEQ and pc_write=!zero for BNE.
REQ-026 JUMP: pc_write=1, pc_src=10; for opcode 000011 additionally reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-027 JR: pc_write=1, pc_src=11.
REQ-028 MEM_WB, MEM_WRITE completion, R_WB, I_WB, BRANCH, JUMP and JR return to FETCH and increment retired.
REQ-029 retired wraps from 0xFFFF to 0x0000.
REQ-030 TRAP is absorbing: illegal=1, all strobes 0, retired frozen; only reset exits.
REQ-031 Latency with mem_ready tied high: LW 5 cycles; SW, R-type and I-type 4; branch, J, JAL and JR 3.

Reset
REQ-032 While reset=0: state=FETCH, retired=0, illegal=0; outputs take their FETCH decode with mem_ready gating.
REQ-033 Reset asserted mid-instruction aborts it immediately; no further strobes are asserted and retired is not incremented.
REQ-034 After release, the first active edge evaluates FETCH.

Structure
REQ-035 A shared package holds the state encodings, opcode and funct constants, ALUOp codes, and the pc_src, alu_src_b, reg_dst and mem_to_reg select codes.
REQ-036 The design uses one sub-module, mc_output_decode, a combinational state/opcode/zero/mem_ready-to-outputs decoder; the next-state register and the retired counter stay in the top level.

Verification
REQ-037 ADD (op 000000, funct 100000) with mem_ready=1 -> state sequence 0,1,6,7,0; reg_write=1 with reg_dst=01 in R_WB only; retired +1.
REQ-038 LW with mem_ready low for 3 cycles in MEM_READ -> mem_read and i_or_d held for 4 cycles; MEM_WB has mem_to_reg=01; total 8 cycles.
REQ-039 BEQ with zero=1, then BNE with zero=1 -> pc_write=1 with pc_src=01 for BEQ; pc_write=0 for BNE; ALUOp 1000 and 1001 respectively.
REQ-040 JAL (000011) -> state JUMP with pc_write=1, pc_src=10, reg_dst=10, mem_to_reg=10; JR (funct 001000) -> pc_src=11.
REQ-041 Opcode 111111 -> TRAP, illegal=1 and held for 10 cycles; reset low for 1 cycle -> state 0, illegal=0.
REQ-042 Preload 65535 retirements (or force the count), then one ADD -> retired=0x0000; reset asserted during EXEC_R -> no reg_write and retired=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-style control unit: states, opcodes,
// ALU class codes and datapath select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_EXEC_I    = 4'd8,
    ST_I_WB      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_JR        = 4'd12,
    ST_TRAP      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_ANDI = 4'b0001;
  localparam logic [3:0] ALU_LW   = 4'b0010;
  localparam logic [3:0] ALU_SW   = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_ORI  = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_R    = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1001;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // Instruction dispatch taken at the end of DECODE.
  function automatic state_t dispatchState(input logic [5:0] opcode, input logic [5:0] funct);
    case (opcode)
      OP_RTYPE:                        return (funct == FN_JR) ? ST_JR : ST_EXEC_R;
      OP_LW, OP_SW:                    return ST_MEM_ADDR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return ST_EXEC_I;
      OP_BEQ, OP_BNE:                  return ST_BRANCH;
      OP_J, OP_JAL:                    return ST_JUMP;
      default:                         return ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decoder: state plus opcode, zero and mem_ready
// select the datapath strobes for the current cycle.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_memReady,
  output logic [3:0]  o_aluOp,
  output logic        o_pcWrite,
  output logic        o_irWrite,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic        o_regWrite,
  output logic        o_iOrD,
  output logic        o_aluSrcA,
  output logic [1:0]  o_pcSrc,
  output logic [1:0]  o_aluSrcB,
  output logic [1:0]  o_regDst,
  output logic [1:0]  o_memToReg
);

  always_comb begin
    o_aluOp    = ALU_ADD;
    o_pcWrite  = 1'b0;
    o_irWrite  = 1'b0;
    o_memRead  = 1'b0;
    o_memWrite = 1'b0;
    o_regWrite = 1'b0;
    o_iOrD     = 1'b0;
    o_aluSrcA  = 1'b0;
    o_pcSrc    = PC_ALU;
    o_aluSrcB  = SRCB_B;
    o_regDst   = DST_RT;
    o_memToReg = WB_ALUOUT;
    case (i_state)
      ST_FETCH: begin
        o_memRead = 1'b1;
        o_aluSrcB = SRCB_FOUR;
        o_irWrite = i_memReady;
        o_pcWrite = i_memReady;
      end
      ST_DECODE: o_aluSrcB = SRCB_IMM_SH;
      ST_MEM_ADDR: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = SRCB_IMM;
        o_aluOp   = (i_opcode == OP_LW) ? ALU_LW : ALU_SW;
      end
      ST_MEM_READ: begin
        o_iOrD    = 1'b1;
        o_memRead = 1'b1;
      end
      ST_MEM_WB: begin
        o_regWrite = 1'b1;
        o_regDst   = DST_RT;
        o_memToReg = WB_MDR;
      end
      ST_MEM_WRITE: begin
        o_iOrD     = 1'b1;
        o_memWrite = 1'b1;
      end
      ST_EXEC_R: begin
        o_aluSrcA = 1'b1;
        o_aluOp   = ALU_R;
      end
      ST_R_WB: begin
        o_regWrite = 1'b1;
        o_regDst   = DST_RD;
      end
      ST_EXEC_I: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = SRCB_IMM;
        case (i_opcode)
          OP_ANDI: o_aluOp = ALU_ANDI;
          OP_ORI:  o_aluOp = ALU_ORI;
          OP_LUI:  o_aluOp = ALU_LUI;
          default: o_aluOp = ALU_ADD;
        endcase
      end
      ST_I_WB: begin
        o_regWrite = 1'b1;
        o_regDst   = DST_RT;
      end
      ST_BRANCH: begin
        o_aluSrcA = 1'b1;
        o_pcSrc   = PC_ALUOUT;
        if (i_opcode == OP_BNE) begin
          o_aluOp   = ALU_BNE;
          o_pcWrite = ~i_zero;
        end else begin
          o_aluOp   = ALU_BEQ;
          o_pcWrite = i_zero;
        end
      end
      // JAL links the return address into $31 while the PC takes the jump target.
      ST_JUMP: begin
        o_pcWrite = 1'b1;
        o_pcSrc   = PC_JUMP;
        if (i_opcode == OP_JAL) begin
          o_regWrite = 1'b1;
          o_regDst   = DST_RA;
          o_memToReg = WB_PC;
        end
      end
      ST_JR: begin
        o_pcWrite = 1'b1;
        o_pcSrc   = PC_RS;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: state register, next-state logic, sticky illegal flag
// and retired-instruction counter; the control word comes from mc_output_decode.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  ALUOp,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        i_or_d,
  output logic        alu_src_a,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [3:0]  state_o,
  output logic        illegal,
  output logic [15:0] retired
);

  state_t      r_state;
  state_t      w_stateNext;
  logic        w_retire;
  logic        r_illegal;
  logic [15:0] r_retired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_FETCH;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_FETCH:     if (mem_ready) w_stateNext = ST_DECODE;
      ST_DECODE:    w_stateNext = dispatchState(opcode, funct);
      ST_MEM_ADDR:  w_stateNext = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_ready) w_stateNext = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) w_stateNext = ST_FETCH;
      ST_EXEC_R:    w_stateNext = ST_R_WB;
      ST_EXEC_I:    w_stateNext = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP, ST_JR:
                    w_stateNext = ST_FETCH;
      ST_TRAP:      w_stateNext = ST_TRAP;
      default:      w_stateNext = ST_FETCH;
    endcase
  end

  // Every return to FETCH from a later state marks a completed instruction.
  assign w_retire = (r_state != ST_FETCH) && (w_stateNext == ST_FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= 16'd0;
      r_illegal <= 1'b0;
    end else begin
      r_retired <= r_retired + {15'd0, w_retire};
      r_illegal <= r_illegal | (w_stateNext == ST_TRAP);
    end
  end

  mc_output_decode u_decode (
    .i_state    (r_state),
    .i_opcode   (opcode),
    .i_zero     (zero),
    .i_memReady (mem_ready),
    .o_aluOp    (ALUOp),
    .o_pcWrite  (pc_write),
    .o_irWrite  (ir_write),
    .o_memRead  (mem_read),
    .o_memWrite (mem_write),
    .o_regWrite (reg_write),
    .o_iOrD     (i_or_d),
    .o_aluSrcA  (alu_src_a),
    .o_pcSrc    (pc_src),
    .o_aluSrcB  (alu_src_b),
    .o_regDst   (reg_dst),
    .o_memToReg (mem_to_reg)
  );

  assign state_o = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule
